// File: rtl/keypad_scan_ctrl.sv
// Keypad scanner: 4x5 active-low matrix, frame debounce, ghost reject, key FIFO.
// Optional auto-repeat is built when KEYPAD_REPEAT_EN is defined.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEB_FRAMES    = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_FRAMES = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_row,
  output logic [3:0] key_col,
  output logic       key_valid,
  output logic [4:0] key_code,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_COL0 = 3'd1;
  localparam logic [2:0] ST_COL1 = 3'd2;
  localparam logic [2:0] ST_COL2 = 3'd3;
  localparam logic [2:0] ST_COL3 = 3'd4;

  localparam logic [4:0] NONE = 5'h1F;

  localparam int CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int MW   = $clog2(DEB_FRAMES + 1);
  localparam int AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;

  localparam logic [CW-1:0]   DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [MW-1:0]   DEB_MAX    = MW'(DEB_FRAMES);
  localparam logic [CNTW-1:0] FIFO_FULL  = CNTW'(FIFO_DEPTH);

  // ---------------- scan sequencer ----------------
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    col_idx;
  logic          last_dwell;
  logic          sample_en;
  logic          frame_close;

  assign last_dwell  = (dwell_q == DWELL_LAST);
  assign sample_en   = (state_q != ST_IDLE) && last_dwell;
  assign frame_close = (state_q == ST_COL3) && last_dwell;

  // Column index of the state being dwelt in
  always_comb begin
    col_idx = 2'd0;
    unique case (state_q)
      ST_COL1: col_idx = 2'd1;
      ST_COL2: col_idx = 2'd2;
      ST_COL3: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Next state and dwell count; scanning runs continuously
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (state_q == ST_IDLE) begin
      state_d = ST_COL0;
      dwell_d = '0;
    end else if (last_dwell) begin
      dwell_d = '0;
      unique case (state_q)
        ST_COL0: state_d = ST_COL1;
        ST_COL1: state_d = ST_COL2;
        ST_COL2: state_d = ST_COL3;
        ST_COL3: state_d = ST_COL0;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      dwell_d = dwell_q + CW'(1);
    end
  end

  // Column drive decoded from the next state so it lines up with the state
  always_comb begin
    col_d = 4'b1111;
    unique case (state_d)
      ST_COL0: col_d = 4'b0111;
      ST_COL1: col_d = 4'b1011;
      ST_COL2: col_d = 4'b1101;
      ST_COL3: col_d = 4'b1110;
      default: col_d = 4'b1111;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      col_q   <= 4'b1111;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      col_q   <= col_d;
    end
  end

  assign key_col = col_q;

  // ---------------- frame capture ----------------
  logic [3:0][4:0] snap_q;
  logic [19:0]     frame_vec;
  logic [1:0]      n_press;
  logic [4:0]      cand_code;
  logic            multi;
  logic [4:0]      cand;

  // Pressed bits (row bit b pressed) to code order (r = 4 - b)
  function automatic logic [4:0] rev5(input logic [4:0] p);
    rev5 = {p[0], p[1], p[2], p[3], p[4]};
  endfunction

  // Snapshot of pressed rows per column, taken on the last dwell cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else if (sample_en) begin
      snap_q[col_idx] <= ~key_row;
    end
  end

  // Whole frame: columns 0..2 from the snapshot, column 3 live
  always_comb begin
    frame_vec = {rev5(~key_row), rev5(snap_q[2]),
                 rev5(snap_q[1]), rev5(snap_q[0])};
  end

  // Count pressed keys (saturating at 2) and find the pressed code
  always_comb begin
    n_press   = 2'd0;
    cand_code = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (frame_vec[i]) begin
        if (n_press != 2'd2) n_press = n_press + 2'd1;
        cand_code = 5'(i);
      end
    end
  end

  assign multi = (n_press == 2'd2);
  assign cand  = (n_press == 2'd0) ? NONE : cand_code;

  // ---------------- debounce and events ----------------
  logic [4:0]    prev_q, prev_d;
  logic [MW-1:0] match_q, match_d;
  logic [4:0]    stable_q, stable_d;
  logic          push_q, push_d;
  logic [4:0]    pcode_q, pcode_d;
  logic          held_q;
  logic [MW-1:0] m_next;

  // Matching-frame count for the current candidate
  always_comb begin
    if (cand != prev_q) begin
      m_next = MW'(1);
    end else if (match_q == DEB_MAX) begin
      m_next = match_q;
    end else begin
      m_next = match_q + MW'(1);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);

  logic [RW-1:0] rep_q, rep_d;
`endif

  // Accept a new stable state and schedule a press (or repeat) event
  always_comb begin
    prev_d   = prev_q;
    match_d  = match_q;
    stable_d = stable_q;
    push_d   = 1'b0;
    pcode_d  = pcode_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d    = rep_q;
`endif
    if (frame_close) begin
      if (multi) begin
        match_d = '0;
      end else begin
        match_d = m_next;
        prev_d  = cand;
        if ((m_next == DEB_MAX) && (cand != stable_q)) begin
          stable_d = cand;
          if (cand != NONE) begin
            push_d  = 1'b1;
            pcode_d = cand;
          end
        end
      end
`ifdef KEYPAD_REPEAT_EN
      if (multi || (stable_d != stable_q)) begin
        rep_d = '0;
      end else if (stable_q != NONE) begin
        if (rep_q == REP_LAST) begin
          rep_d   = '0;
          push_d  = 1'b1;
          pcode_d = stable_q;
        end else begin
          rep_d = rep_q + RW'(1);
        end
      end
`endif
    end
  end

  // Debounce and event registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= NONE;
      match_q  <= '0;
      stable_q <= NONE;
      push_q   <= 1'b0;
      pcode_q  <= '0;
      held_q   <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      match_q  <= match_d;
      stable_q <= stable_d;
      push_q   <= push_d;
      pcode_q  <= pcode_d;
      held_q   <= (stable_q != NONE);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Repeat frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign key_held = held_q;

  // ---------------- event FIFO ----------------
  logic [4:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [CNTW-1:0] cnt_q;
  logic            ovf_q;
  logic            full;
  logic            do_pop;
  logic            do_push;
  logic            drop;

  assign full    = (cnt_q == FIFO_FULL);
  assign do_pop  = (cnt_q != '0) && key_ready;
  assign do_push = push_q && (!full || do_pop);
  assign drop    = push_q && full && !do_pop;

  // Storage; contents are qualified by the count so need no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wp_q] <= pcode_q;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (overflow_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign key_valid = (cnt_q != '0);
  assign key_code  = key_valid ? mem_q[rp_q] : 5'd0;
  assign overflow  = ovf_q;

endmodule
